// File: rtl/demux_scheduler.sv
// demux_scheduler: accepts one word at a time and routes it to one of eight
// channels, chosen round-robin among the enabled channels. The word is held
// on out_data/out_valid/sel until that channel's sink takes it.
module demux_scheduler #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        chan_en,
  input  logic [7:0]        out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [7:0]        out_valid,
  output logic [2:0]        sel,
  output logic              busy,
  output logic [15:0]       disp_count
);

  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

  state_t     state;
  state_t     state_nxt;
  logic [2:0] ptr;
  logic [2:0] grant;
  logic       accept;
  logic       release_hit;

  // First enabled channel found when searching start, start+1, ... (mod 8).
  function automatic logic [2:0] rr_pick(input logic [7:0] en, input logic [2:0] start);
    logic [2:0] res;
    logic [2:0] idx;
    logic       found;
    res   = start;
    found = 1'b0;
    for (int k = 0; k < 8; k++) begin
      idx = start + 3'(k);
      if (!found && en[idx]) begin
        res   = idx;
        found = 1'b1;
      end
    end
    return res;
  endfunction

  assign grant = rr_pick(chan_en, ptr);

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic: accept moves to HOLD, the selected sink's ready releases it.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)      state_nxt = HOLD;
      HOLD:    if (release_hit) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output/handshake decode; in_ready is forced low while reset is asserted.
  always_comb begin
    in_ready    = (state == IDLE) && rst_n && (chan_en != 8'h00);
    busy        = (state == HOLD);
    accept      = in_valid && in_ready;
    release_hit = (state == HOLD) && out_ready[sel];
  end

  // Held word, grant, pointer and dispatch counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr        <= 3'd0;
      sel        <= 3'd0;
      out_valid  <= 8'h00;
      out_data   <= '0;
      disp_count <= 16'h0000;
    end else if (accept) begin
      out_data  <= in_data;
      sel       <= grant;
      out_valid <= 8'h01 << grant;
    end else if (release_hit) begin
      out_valid  <= 8'h00;
      ptr        <= sel + 3'd1;
      disp_count <= disp_count + 16'd1;
    end
  end

endmodule

// File: doc/demux_scheduler.md
DEMUX_SCHEDULER -- requirements
Module: demux_scheduler

Interface
REQ-001 Parameter DATA_W, default 8, width of the data word routed to each channel.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low; sampled on rising edge of clk.
REQ-004 in_data  input  DATA_W  word to be dispatched.
REQ-005 in_valid  input  1  in_data valid.
REQ-006 in_ready  output  1  block accepts in_data this cycle; transfer occurs when in_valid && in_ready at a rising edge.
REQ-007 chan_en  input  8  per-channel enable mask; bit i = channel i eligible for dispatch.
REQ-008 out_ready  input  8  per-channel sink ready.
REQ-009 out_data  output  DATA_W  registered word presented to the granted channel.
REQ-010 out_valid  output  8  registered, one-hot or zero; bit i = word valid for channel i.
REQ-011 sel  output  3  registered index of the channel currently or last granted (demux select).
REQ-012 busy  output  1  high while a word is held awaiting acceptance.
REQ-013 disp_count  output  16  registered count of completed dispatches.

Function
REQ-014 FSM SHALL have two states: IDLE and HOLD; busy = (state == HOLD).
REQ-015 in_ready SHALL be 1 only when state == IDLE, rst_n == 1, and chan_en != 0; otherwise 0.
REQ-016 Internal 3-bit round-robin pointer ptr SHALL define search order ptr, ptr+1, ..., ptr+7 (mod 8); grant = first index in that order with chan_en bit set.
REQ-017 On an input transfer in IDLE at edge N: out_data <= in_data, sel <= grant, out_valid <= one-hot(grant), state <= HOLD; out_valid visible one cycle after edge N (latency 1).
REQ-018 In HOLD, out_data, sel, out_valid SHALL stay constant until out_ready[sel] == 1 at a rising edge.
REQ-019 On that edge: out_valid <= 0, ptr <= sel + 1 (mod 8, 7 wraps to 0), disp_count <= disp_count + 1, state <= IDLE.
REQ-020 disp_count SHALL wrap from 16'hFFFF to 0 without saturation or flag.
REQ-021 out_ready bits other than out_ready[sel] SHALL be ignored; out_ready SHALL be ignored in IDLE.
REQ-022 chan_en changes during HOLD SHALL NOT affect the held transfer; chan_en is sampled only at the accepting edge in IDLE.
REQ-023 chan_en == 0 in IDLE: in_ready = 0, no state change, in_valid may remain asserted indefinitely.
REQ-024 Maximum throughput SHALL be one word per two cycles (accept edge, then release edge); no back-to-back acceptance in HOLD.
REQ-025 out_data SHALL retain its last value when out_valid == 0.
REQ-026 out_valid SHALL never have more than one bit set.

Reset
REQ-027 While rst_n == 0 at a rising edge: state <= IDLE, ptr <= 0, sel <= 0, out_valid <= 0, out_data <= 0, disp_count <= 0.
REQ-028 in_ready SHALL be 0 combinationally whenever rst_n == 0.
REQ-029 Reset asserted during HOLD SHALL discard the held word; disp_count SHALL NOT increment for it.
REQ-030 After rst_n returns high, first grant SHALL search from channel 0.

Verification
REQ-031 chan_en=8'hFF, all out_ready=1, 9 words 0x10..0x18 sent back-to-back -> out_valid one-hot sequence ch0..ch7 then ch0; each word appears one cycle after acceptance; disp_count=9.
REQ-032 chan_en=8'b1010_0100, out_ready=8'hFF, 4 words -> grants ch2, ch5, ch7, ch2; sel matches each.
REQ-033 Word 0xA5 granted to ch3, out_ready[3]=0 for 5 cycles with out_ready[4]=1 -> out_valid=8'h08, out_data=0xA5, in_ready=0, busy=1 held all 5 cycles; released on first cycle out_ready[3]=1.
REQ-034 chan_en=0 with in_valid=1 for 4 cycles -> in_ready=0, out_valid=0; set chan_en=8'h40 -> word accepted, granted to ch6.
REQ-035 rst_n=0 for one edge while in HOLD on ch5 -> next cycle out_valid=0, sel=0, disp_count=0, busy=0; next word granted to ch0.
REQ-036 Preload via 65535 dispatches then one more -> disp_count wraps to 0.
